// File: rtl/restoring_divider.sv
// restoring_divider: sequential unsigned restoring divider, one quotient bit per clock
module restoring_divider #(
  parameter int WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             start_i,
  input  logic [WIDTH-1:0] dividend_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] quotient_o,
  output logic [WIDTH-1:0] remainder_o,
  output logic             div_by_zero_o
);
  localparam int CW = $clog2(WIDTH);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state_q, state_d;
  logic [WIDTH-1:0] d_q, d_d, q_q, q_d, r_q, r_d;
  logic [WIDTH-1:0] quot_q, quot_d, rem_q, rem_d;
  logic             dbz_q, dbz_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             load, zero, last;
  logic [WIDTH:0]   rs, t;
  logic [WIDTH-1:0] r_nx, q_nx;
  assign load = state_q == IDLE && start_i;
  assign zero = divisor_i == '0;
  assign last = cnt_q == CW'(WIDTH - 1);
  // R < D keeps the shifted remainder below 2^(WIDTH+1), so T's MSB is a clean sign bit
  assign rs   = {r_q, q_q[WIDTH-1]};
  assign t    = rs - {1'b0, d_q};
  assign r_nx = t[WIDTH] ? rs[WIDTH-1:0] : t[WIDTH-1:0];
  assign q_nx = {q_q[WIDTH-2:0], ~t[WIDTH]};
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) state_q <= IDLE;
    else         state_q <= state_d;
  end
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = start_i ? (zero ? DONE : RUN) : IDLE;
      RUN:     state_d = last ? DONE : RUN;
      DONE:    state_d = start_i ? DONE : IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_comb begin
    busy_o = state_q == RUN;
    done_o = state_q == DONE;
  end
  always_comb begin
    d_d    = d_q;
    q_d    = q_q;
    r_d    = r_q;
    cnt_d  = cnt_q;
    quot_d = quot_q;
    rem_d  = rem_q;
    dbz_d  = dbz_q;
    if (load && !zero) begin
      d_d   = divisor_i;
      q_d   = dividend_i;
      r_d   = '0;
      cnt_d = '0;
    end
    if (load && zero) begin
      quot_d = '1;
      rem_d  = dividend_i;
      dbz_d  = 1'b1;
    end
    if (state_q == RUN) begin
      q_d   = q_nx;
      r_d   = r_nx;
      cnt_d = cnt_q + 1'b1;
      if (last) begin
        quot_d = q_nx;
        rem_d  = r_nx;
        dbz_d  = 1'b0;
      end
    end
  end
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      d_q    <= '0;
      q_q    <= '0;
      r_q    <= '0;
      cnt_q  <= '0;
      quot_q <= '0;
      rem_q  <= '0;
      dbz_q  <= 1'b0;
    end else begin
      d_q    <= d_d;
      q_q    <= q_d;
      r_q    <= r_d;
      cnt_q  <= cnt_d;
      quot_q <= quot_d;
      rem_q  <= rem_d;
      dbz_q  <= dbz_d;
    end
  end
  assign quotient_o    = quot_q;
  assign remainder_o   = rem_q;
  assign div_by_zero_o = dbz_q;
endmodule

// File: tb/tb_restoring_divider.sv
// tb_restoring_divider: randomized scoreboard bench for restoring_divider
module tb_restoring_divider;
  localparam int W = 8;
  logic         clk = 1'b0, rst = 1'b1, start = 1'b0;
  logic [W-1:0] dvd = '0, dvs = '0;
  logic         busy_o, done_o, dbz_o;
  logic [W-1:0] quot_o, rem_o;
  typedef struct packed {logic [W-1:0] q; logic [W-1:0] r; logic z;} res_t;
  res_t sbq[$];
  res_t held = '0;
  int   checks = 0, failures = 0, completions = 0;
  logic done_prev = 1'b0;
  restoring_divider #(.WIDTH(W)) dut (
    .clk_i(clk), .reset_i(rst), .start_i(start), .dividend_i(dvd), .divisor_i(dvs),
    .busy_o(busy_o), .done_o(done_o), .quotient_o(quot_o), .remainder_o(rem_o),
    .div_by_zero_o(dbz_o)
  );
  always #5 clk = ~clk;
  function automatic res_t model(input logic [W-1:0] a, input logic [W-1:0] b);
    res_t e;
    if (b == 0) begin
      e.q = '1; e.r = a; e.z = 1'b1;
    end else begin
      e.q = a / b; e.r = a % b; e.z = 1'b0;
    end
    return e;
  endfunction
  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask
  // monitor: pops the scoreboard on each entry into DONE
  always @(negedge clk) begin
    if (rst) done_prev <= 1'b0;
    else begin
      chk("busy_done_exclusive", int'(busy_o & done_o), 0);
      if (busy_o) begin
        chk("hold_quotient", quot_o, held.q);
        chk("hold_remainder", rem_o, held.r);
        chk("hold_dbz", dbz_o, held.z);
      end
      if (done_o && !done_prev) begin
        completions++;
        if (sbq.size() == 0) chk("unexpected_done", 1, 0);
        else begin
          res_t e;
          e = sbq.pop_front();
          chk("quotient", quot_o, e.q);
          chk("remainder", rem_o, e.r);
          chk("div_by_zero", dbz_o, e.z);
          held = e;
        end
      end
      done_prev <= done_o;
    end
  end
  task automatic wait_done(input int exp_lat, input bit scramble);
    int n = 0, nb = 0;
    do begin
      @(posedge clk);
      n++;
      #1;
      if (busy_o) nb++;
      if (scramble && busy_o) begin
        dvd = 8'hFF;
        dvs = 8'h01;
      end
    end while (!done_o && n < 3 * W);
    chk("latency", n, exp_lat);
    chk("busy_cycles", nb, exp_lat - 1);
  endtask
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input int hold,
                        input bit scramble);
    @(negedge clk);
    dvd = a;
    dvs = b;
    start = 1'b1;
    sbq.push_back(model(a, b));
    wait_done(b == 0 ? 1 : W + 1, scramble);
    repeat (hold) begin
      @(negedge clk);
      chk("done_held", done_o, 1);
    end
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    chk("back_to_idle", done_o, 0);
  endtask
  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end
  initial begin
    int c0;
    repeat (2) @(negedge clk);
    chk("reset_quotient", quot_o, 0);
    chk("reset_remainder", rem_o, 0);
    chk("reset_dbz", dbz_o, 0);
    chk("reset_busy", busy_o, 0);
    chk("reset_done", done_o, 0);
    rst = 1'b0;
    run_op(8'd100, 8'd7, 3, 1'b0);
    run_op(8'd255, 8'd1, 0, 1'b0);
    run_op(8'd5, 8'd9, 0, 1'b0);
    run_op(8'd200, 8'd0, 0, 1'b0);
    run_op(8'd9, 8'd3, 0, 1'b0);
    c0 = completions;
    run_op(8'd50, 8'd6, 20, 1'b0);
    chk("single_op_while_held", completions - c0, 1);
    run_op(8'd77, 8'd10, 0, 1'b1);
    // abandon 250/13 mid-RUN with an asynchronous reset between edges
    @(negedge clk);
    dvd = 8'd250;
    dvs = 8'd13;
    start = 1'b1;
    repeat (4) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_quotient", quot_o, 0);
    chk("async_rst_remainder", rem_o, 0);
    chk("async_rst_dbz", dbz_o, 0);
    chk("async_rst_busy", busy_o, 0);
    chk("async_rst_done", done_o, 0);
    held = '0;
    sbq.push_back(model(8'd250, 8'd13));
    @(negedge clk);
    rst = 1'b0;
    wait_done(W + 1, 1'b0);
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 40; i++) begin
      logic [W-1:0] a, b;
      a = W'($urandom);
      b = ($urandom_range(0, 4) == 0) ? '0 : W'($urandom);
      if (i % 7 == 0 && b != 0) b = a + W'($urandom_range(1, 3));
      run_op(a, b, $urandom_range(0, 2), 1'($urandom_range(0, 1)));
    end
    chk("scoreboard_empty", sbq.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
